// File: rtl/telem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : telem_pkg
//  Brief    : Shared types and constants for the telemetry frame sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package telem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } telem_state_t;

    localparam logic [7:0] HDR_HI        = 8'hAA;
    localparam logic [7:0] HDR_LO        = 8'h55;
    localparam int         MAX_NUM_BYTES = 14;

endpackage : telem_pkg
`default_nettype wire

// File: rtl/telem_tx_seq.sv
`default_nettype none
// ============================================================================
//  Module   : telem_tx_seq
//  Brief    : Sends AA,55,payload[,checksum] to a UART transmitter, one trmt
//             per byte, advancing on each rising edge of tx_done.
//             Define TELEM_CHKSUM_EN to append the ~sum(payload) byte.
//  Revision : 1.0 - initial release
// ============================================================================
module telem_tx_seq
    import telem_pkg::*;
#(
    parameter int NUM_BYTES = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snd,
    input  logic [8*NUM_BYTES-1:0] payload,
    input  logic                   tx_done,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   frm_done
);

`ifdef TELEM_CHKSUM_EN
    localparam int FRM_LEN = NUM_BYTES + 3;
`else
    localparam int FRM_LEN = NUM_BYTES + 2;
`endif

    // Four bits covers every legal frame except 14 bytes plus checksum.
    localparam int                 CNT_W     = (FRM_LEN > 16) ? 5 : 4;
    localparam int                 SEL_DEPTH = 2 ** CNT_W;
    localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(FRM_LEN - 1);
    localparam logic [CNT_W-1:0]   FIRST_PAY = CNT_W'(2);
    localparam logic [CNT_W-1:0]   LAST_PAY  = CNT_W'(NUM_BYTES + 1);

    telem_state_t           r_state;
    logic [8*NUM_BYTES-1:0] r_shadow;
    logic [CNT_W-1:0]       r_byte_cnt;
    logic                   r_tx_done_q;
    logic                   r_trmt;
    logic [7:0]             r_tx_data;
    logic                   r_busy;
    logic                   r_frm_done;
`ifdef TELEM_CHKSUM_EN
    logic [7:0]             r_chk_acc;
`endif

    logic                   w_done_rise;
    logic                   w_is_payload;
    logic [CNT_W-1:0]       w_pay_idx;
    logic [7:0]             w_byte;
    logic [7:0]             w_pay_bytes [SEL_DEPTH];

    assign w_done_rise  = tx_done & ~r_tx_done_q;
    assign w_is_payload = (r_byte_cnt >= FIRST_PAY) && (r_byte_cnt <= LAST_PAY);
    assign w_pay_idx    = r_byte_cnt - FIRST_PAY;

    // Byte 0 of the payload sits in the most significant byte lane.
    for (genvar gi = 0; gi < SEL_DEPTH; gi++) begin : g_pay_sel
        if (gi < NUM_BYTES) begin : g_used
            assign w_pay_bytes[gi] = r_shadow[8*(NUM_BYTES-gi)-1 -: 8];
        end else begin : g_pad
            assign w_pay_bytes[gi] = 8'h00;
        end
    end

    always_comb begin
        w_byte = 8'h00;
        if (r_byte_cnt == '0) begin
            w_byte = HDR_HI;
        end else if (r_byte_cnt == CNT_W'(1)) begin
            w_byte = HDR_LO;
        end else if (w_is_payload) begin
            w_byte = w_pay_bytes[w_pay_idx];
        end else begin
`ifdef TELEM_CHKSUM_EN
            w_byte = ~r_chk_acc;
`else
            w_byte = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_byte_cnt  <= '0;
            r_tx_done_q <= 1'b0;
            r_trmt      <= 1'b0;
            r_tx_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_frm_done  <= 1'b0;
`ifdef TELEM_CHKSUM_EN
            r_chk_acc   <= 8'h00;
`endif
        end else begin
            r_tx_done_q <= tx_done;
            r_trmt      <= 1'b0;
            r_frm_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (snd) begin
                        r_shadow   <= payload;
                        r_byte_cnt <= '0;
                        r_busy     <= 1'b1;
`ifdef TELEM_CHKSUM_EN
                        r_chk_acc  <= 8'h00;
`endif
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx_data <= w_byte;
                    r_trmt    <= 1'b1;
`ifdef TELEM_CHKSUM_EN
                    if (w_is_payload) begin
                        r_chk_acc <= r_chk_acc + w_byte;
                    end
`endif
                    r_state   <= WAIT;
                end
                WAIT: begin
                    // Only a fresh rising edge counts; a level left high by
                    // the previous byte must not advance the frame.
                    if (w_done_rise) begin
                        if (r_byte_cnt == LAST_IDX) begin
                            r_frm_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                            r_state    <= LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign trmt     = r_trmt;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign frm_done = r_frm_done;

endmodule : telem_tx_seq
`default_nettype wire

// File: tb/tb_telem_tx_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_telem_tx_seq
//  Brief    : Directed bench for telem_tx_seq with a behavioural UART model
//             and an expected-byte queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_telem_tx_seq;

`ifdef TELEM_CHKSUM_EN
    localparam int FRM_LEN = 9;
`else
    localparam int FRM_LEN = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd = 1'b0;
    logic [47:0] payload = '0;
    logic        tx_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;
    logic        frm_done;

    logic        init_done = 1'b0;
    int          cd;
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_frames = 0;
    int          frm_trmts = 0;
    logic        prev_trmt = 1'b0;
    logic        prev_done = 1'b0;
    logic [7:0]  last_byte = 8'h00;
    logic [7:0]  exp_q [$];

    telem_tx_seq #(.NUM_BYTES(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .snd      (snd),
        .payload  (payload),
        .tx_done  (tx_done),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .busy     (busy),
        .frm_done (frm_done)
    );

    always #5 clk = ~clk;

    // UART model: drops tx_done on trmt, raises it 100 cycles later.
    always @(posedge clk) begin
        if (!rst_n) begin
            tx_done <= init_done;
            cd      <= 0;
        end else if (trmt) begin
            tx_done <= 1'b0;
            cd      <= 100;
        end else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1) tx_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [47:0] p);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 6; i++) begin
            b = p[47-8*i -: 8];
            exp_q.push_back(b);
            s = s + b;
        end
`ifdef TELEM_CHKSUM_EN
        exp_q.push_back(~s);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (trmt) begin
                chk("trmt_single_cycle", {31'b0, prev_trmt}, 32'd0);
                chk("trmt_expected", {31'b0, (exp_q.size() > 0)}, 32'd1);
                if (exp_q.size() > 0) begin
                    last_byte = exp_q.pop_front();
                    chk("tx_data", {24'b0, tx_data}, {24'b0, last_byte});
                end
                frm_trmts++;
            end
            if (tx_done && !prev_done && busy)
                chk("tx_data_hold", {24'b0, tx_data}, {24'b0, last_byte});
            if (frm_done) begin
                chk("busy_at_frm_done", {31'b0, busy}, 32'd0);
                chk("trmt_count", frm_trmts, FRM_LEN);
                frm_trmts = 0;
                n_frames++;
            end
            prev_trmt = trmt;
            prev_done = tx_done;
        end else begin
            prev_trmt = 1'b0;
            prev_done = tx_done;
            frm_trmts = 0;
        end
    end

    task automatic start_check(input logic [47:0] p);
        payload = p;
        push_frame(p);
        snd = 1'b1;
        @(negedge clk);
        snd = 1'b0;
        chk("busy_after_snd", {31'b0, busy}, 32'd1);
        chk("trmt_lat_1", {31'b0, trmt}, 32'd0);
        @(negedge clk);
        chk("trmt_lat_2", {31'b0, trmt}, 32'd1);
    endtask

    task automatic wait_frm_done(input string tag);
        int k;
        k = 0;
        while (!frm_done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_frm_done"}, {31'b0, frm_done}, 32'd1);
    endtask

    initial begin
        int k;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_trmt", {31'b0, trmt}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frm_done", {31'b0, frm_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, then all-ones payload
        start_check(48'h010203040506);
        wait_frm_done("basic");
        @(negedge clk);
        start_check(48'hFFFFFFFFFFFF);
        wait_frm_done("ones");
        @(negedge clk);

        // snd while busy is ignored; snd in the frm_done cycle is accepted
        start_check(48'h1122334455AA);
        repeat (250) @(negedge clk);
        payload = 48'hDEADBEEFCAFE;
        snd = 1'b1;
        @(negedge clk);
        snd = 1'b0;
        wait_frm_done("busy_ign");
        start_check(48'h0F1E2D3C4B5A);
        wait_frm_done("frm_done_snd");
        repeat (20) @(negedge clk);
        chk("no_extra_frame", {31'b0, busy}, 32'd0);

        // Reset during byte 3
        start_check(48'hA1B2C3D4E5F6);
        k = 0;
        while (frm_trmts < 3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_byte3", frm_trmts, 32'd3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_trmt", {31'b0, trmt}, 32'd0);
        chk("midrst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        start_check(48'h123456789ABC);
        wait_frm_done("after_rst");
        @(negedge clk);

        // tx_done already high out of reset
        init_done = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("stale_tx_done_high", {31'b0, tx_done}, 32'd1);
        start_check(48'h0102A0B0C0D0);
        repeat (20) @(negedge clk);
        chk("stale_no_advance", frm_trmts, 32'd1);
        chk("stale_busy", {31'b0, busy}, 32'd1);
        wait_frm_done("stale");
        @(negedge clk);

        // Back-to-back frames with snd held high
        payload = 48'h5566778899AB;
        push_frame(payload);
        push_frame(payload);
        snd = 1'b1;
        @(negedge clk);
        wait_frm_done("b2b_1");
        @(negedge clk);
        chk("b2b_idle_one_cycle", {31'b0, busy}, 32'd1);
        snd = 1'b0;
        @(negedge clk);
        chk("b2b_trmt", {31'b0, trmt}, 32'd1);
        wait_frm_done("b2b_2");
        @(negedge clk);
        chk("b2b_end_idle", {31'b0, busy}, 32'd0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("frame_count", n_frames, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_telem_tx_seq
`default_nettype wire
